serializer_arbiter: RTL

//   Round-robin arbiter that shares one serializer_fsm between N parallel-word requesters in the FIR path.

---
 rtl/serializer_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter sharing one serializer between N_REQ parallel-word requesters.
// Grants a requester, hands its word to the serializer, acks on latch and holds until shift-out ends.
module serializer_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LENGTH  = 24,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic [N_REQ*LENGTH-1:0]    iv_req_din,
  input  logic [N_REQ-1:0]           iv_req_valid,
  output logic [N_REQ-1:0]           ov_req_ack,
  output logic [LENGTH-1:0]          ov_ser_din,
  output logic                       o_ser_din_valid,
  input  logic                       i_ser_consumed,
  input  logic                       i_ser_busy,
  output logic [$clog2(N_REQ)-1:0]   ov_grant,
  output logic                       o_busy,
  output logic                       o_error,
  input  logic                       i_err_clr
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef logic [GW-1:0] idx_t;
  typedef enum logic [1:0] {StIdle, StReq, StShift, StDrain} state_e;

  state_e         state_q;
  idx_t           rr_ptr_q;
  idx_t           grant_q;
  logic [TW-1:0]  timer_q;

  logic [LENGTH-1:0] words [N_REQ];
  idx_t              pick;
  logic              pick_vld;
  idx_t              scan_idx;
  int unsigned       scan;
  idx_t              grant_nxt;
  logic              timer_hit;

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = iv_req_din[g*LENGTH +: LENGTH];
  end

  // First pending requester scanning from rr_ptr upward, wrapping past N_REQ-1.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan     = 0;
    scan_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan     = (32'(rr_ptr_q) + i) % N_REQ;
      scan_idx = idx_t'(scan);
      if (!pick_vld && iv_req_valid[scan_idx]) begin
        pick_vld = 1'b1;
        pick     = scan_idx;
      end
    end
  end

  assign grant_nxt = (grant_q == idx_t'(N_REQ - 1)) ? '0 : grant_q + idx_t'(1);
  assign timer_hit = (timer_q == TW'(TIMEOUT - 1));
  assign ov_grant  = grant_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= StIdle;
      rr_ptr_q        <= '0;
      grant_q         <= '0;
      timer_q         <= '0;
      ov_req_ack      <= '0;
      ov_ser_din      <= '0;
      o_ser_din_valid <= 1'b0;
      o_busy          <= 1'b0;
      o_error         <= 1'b0;
    end else if (i_en) begin
      ov_req_ack <= '0;
      // A timeout in the same cycle overrides the clear below.
      if (i_err_clr) o_error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A still-shifting serializer (e.g. after reset) blocks new grants.
          if (pick_vld && !i_ser_busy) begin
            grant_q         <= pick;
            ov_ser_din      <= words[pick];
            o_ser_din_valid <= 1'b1;
            o_busy          <= 1'b1;
            timer_q         <= '0;
            state_q         <= StReq;
          end
        end
        StReq: begin
          if (i_ser_consumed) begin
            o_ser_din_valid     <= 1'b0;
            ov_req_ack[grant_q] <= 1'b1;
            timer_q             <= '0;
            state_q             <= StShift;
          end else if (timer_hit) begin
            o_ser_din_valid <= 1'b0;
            o_error         <= 1'b1;
            rr_ptr_q        <= grant_nxt;
            o_busy          <= 1'b0;
            state_q         <= StIdle;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StShift: begin
          if (i_ser_busy) begin
            state_q <= StDrain;
          end else if (timer_hit) begin
            o_error  <= 1'b1;
            rr_ptr_q <= grant_nxt;
            o_busy   <= 1'b0;
            state_q  <= StIdle;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StDrain: begin
          if (!i_ser_busy) begin
            rr_ptr_q <= grant_nxt;
            o_busy   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
